// File: rtl/fifo_pkg.sv
// ---------------------------------------------------------------------------
// fifo_pkg
//   Shared helpers for both sides of the async FIFO. The write-side arbiter
//   and the read-side empty logic both use them.
//   - fifo_depth : number of entries for a given address width
//   - bin2gray   : binary to reflected Gray code
//   - gray2bin   : reflected Gray code to binary
//   The conversions work on 32-bit values. Callers zero-extend their
//   pointers going in and truncate the result coming out, so one function
//   serves every pointer width.
// ---------------------------------------------------------------------------
package fifo_pkg;

  function automatic int fifo_depth(input int addr_size);
    return 1 << addr_size;
  endfunction

  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  // Each binary bit is the XOR of all Gray bits at or above it.
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// ---------------------------------------------------------------------------
// fifo_wr_arbiter_if
//   Write-side bus of the async FIFO. It groups the requester handshake, the
//   memory write port, the synchronized read pointer and the status flags.
//   master : requesters / read-pointer synchronizer / memory (environment)
//   slave  : fifo_wr_arbiter
//   Signals:
//     REQ, REQ_DATA   requester write requests and their packed words
//     GNT             one-hot grant back to the requesters
//     WQ2_RPTR        Gray read pointer after the 2-flop synchronizer
//     WCLKEN, WADDR,
//     WDATA           memory write port
//     WPTR            Gray write pointer, sent to the write-to-read sync
//     WFULL, WALMOST_FULL, WLEVEL   registered status
// ---------------------------------------------------------------------------
interface fifo_wr_arbiter_if #(
  parameter int ADDR_SIZE = 4,
  parameter int DATA_SIZE = 8,
  parameter int NUM_REQ   = 4
);

  logic [NUM_REQ-1:0]           REQ;
  logic [NUM_REQ*DATA_SIZE-1:0] REQ_DATA;
  logic [NUM_REQ-1:0]           GNT;
  logic [ADDR_SIZE:0]           WQ2_RPTR;
  logic                         WCLKEN;
  logic [ADDR_SIZE-1:0]         WADDR;
  logic [DATA_SIZE-1:0]         WDATA;
  logic [ADDR_SIZE:0]           WPTR;
  logic                         WFULL;
  logic                         WALMOST_FULL;
  logic [ADDR_SIZE:0]           WLEVEL;

  modport master (
    output REQ, REQ_DATA, WQ2_RPTR,
    input  GNT, WCLKEN, WADDR, WDATA, WPTR, WFULL, WALMOST_FULL, WLEVEL
  );

  modport slave (
    input  REQ, REQ_DATA, WQ2_RPTR,
    output GNT, WCLKEN, WADDR, WDATA, WPTR, WFULL, WALMOST_FULL, WLEVEL
  );

endinterface

// File: rtl/fifo_wr_arbiter_rr.sv
// ---------------------------------------------------------------------------
// rr_arbiter
//   Combinational round-robin arbiter with a registered priority pointer.
//   The search for a requester starts at the priority pointer and wraps. After
//   a grant, the pointer moves to the slot just past the winner. This way a
//   lone requester wins every cycle and contending requesters take turns.
//   Ports:
//     clk  in   clock
//     rst  in   synchronous active-high reset (priority returns to slot 0)
//     en   in   grant enable; no grant is issued while low
//     req  in   request vector
//     gnt  out  one-hot grant (all zero when nothing is granted)
// ---------------------------------------------------------------------------
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PW-1:0] prio_q;
  logic [PW-1:0] prio_nx;
  int            idx;

  // NOTE: every signal written here gets a default at the top of the block.
  // That prevents latch inference when no requester matches.
  always_comb begin
    gnt     = '0;
    prio_nx = prio_q;
    idx     = 0;
    if (en) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        idx = (int'(prio_q) + k) % NUM_REQ;
        if (req[idx] && (gnt == '0)) begin
          gnt[idx] = 1'b1;
          prio_nx  = PW'((idx + 1) % NUM_REQ);
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  // Reset is synchronous, so it is sampled at the clock edge like any other input.
  always_ff @(posedge clk) begin
    if (rst) begin
      prio_q <= '0;
    end else begin
      prio_q <= prio_nx;
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// fifo_wr_arbiter
//   Write-side controller of the async FIFO, in the WCLK domain. It shares the
//   single memory write port among NUM_REQ requesters through rr_arbiter. It
//   owns the binary/Gray write pointer and derives WFULL, WALMOST_FULL and
//   WLEVEL from the synchronized Gray read pointer. The flags are pessimistic:
//   a read is seen only after the synchronizer, so they clear late but never
//   early.
//   Ports:
//     WCLK    in     write-domain clock
//     WRST    in     synchronous reset, active-high
//     wr_bus  slave  see fifo_wr_arbiter_if (REQ/REQ_DATA/GNT handshake,
//                    WQ2_RPTR in, memory write port and status out)
// ---------------------------------------------------------------------------
module fifo_wr_arbiter
  import fifo_pkg::*;
#(
  parameter int ADDR_SIZE = 4,
  parameter int DATA_SIZE = 8,
  parameter int NUM_REQ   = 4,
  parameter int AFULL_TH  = 2
) (
  input  logic              WCLK,
  input  logic              WRST,
  fifo_wr_arbiter_if.slave  wr_bus
);

  localparam int                 PW      = ADDR_SIZE + 1;
  localparam int                 DEPTH   = fifo_depth(ADDR_SIZE);
  localparam logic [ADDR_SIZE:0] DEPTH_W = PW'(DEPTH);
  localparam logic [ADDR_SIZE:0] AF_TH_W = PW'(AFULL_TH);

  logic [ADDR_SIZE:0]   wbin_q;
  logic [ADDR_SIZE:0]   wptr_q;
  logic                 wfull_q;
  logic                 wafull_q;
  logic [ADDR_SIZE:0]   wlevel_q;

  logic [NUM_REQ-1:0]   gnt;
  logic                 wclken;
  logic [DATA_SIZE-1:0] wdata;
  logic [ADDR_SIZE:0]   wbin_nx;
  logic [ADDR_SIZE:0]   wgray_nx;
  logic [ADDR_SIZE:0]   rbin;
  logic [ADDR_SIZE:0]   level_nx;
  logic [ADDR_SIZE:0]   free_nx;
  logic [ADDR_SIZE:0]   full_cmp;
  logic                 full_nx;
  logic                 afull_nx;

  // Arbitration is blocked during reset and while full. The in-flight request
  // at a reset edge is therefore dropped, and a full FIFO is never written.
  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr (
    .clk (WCLK),
    .rst (WRST),
    .en  (~WRST & ~wfull_q),
    .req (wr_bus.REQ),
    .gnt (gnt)
  );

  assign wclken = |gnt;

  // Data mux. The grant is one-hot, so OR-ing the masked slices selects the
  // winner's word, and the result is zero when nothing is granted.
  always_comb begin
    wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        wdata = wdata | wr_bus.REQ_DATA[i*DATA_SIZE +: DATA_SIZE];
      end
    end
  end

  // Next-state pointer math. It wraps mod 2*DEPTH, and the MSB is the lap bit.
  // A read seen on WQ2_RPTR and a write in the same cycle both land here, so
  // the level is unchanged when both happen.
  always_comb begin
    wbin_nx  = wbin_q + {{ADDR_SIZE{1'b0}}, wclken};
    wgray_nx = PW'(bin2gray(32'(wbin_nx)));
    rbin     = PW'(gray2bin(32'(wr_bus.WQ2_RPTR)));
    level_nx = wbin_nx - rbin;
    free_nx  = DEPTH_W - level_nx;
    // Full in Gray space: the write pointer is one lap ahead of the read
    // pointer. That means the top two Gray bits are inverted and the rest match.
    full_cmp = {~wr_bus.WQ2_RPTR[ADDR_SIZE:ADDR_SIZE-1],
                wr_bus.WQ2_RPTR[ADDR_SIZE-2:0]};
    full_nx  = (wgray_nx == full_cmp);
    afull_nx = (free_nx <= AF_TH_W);
  end

  always_ff @(posedge WCLK) begin
    if (WRST) begin
      wbin_q   <= '0;
      wptr_q   <= '0;
      wfull_q  <= 1'b0;
      wafull_q <= 1'b0;
      wlevel_q <= '0;
    end else begin
      wbin_q   <= wbin_nx;
      wptr_q   <= wgray_nx;
      wfull_q  <= full_nx;
      wafull_q <= afull_nx;
      wlevel_q <= level_nx;
    end
  end

  assign wr_bus.GNT          = gnt;
  assign wr_bus.WCLKEN       = wclken;
  assign wr_bus.WADDR        = wbin_q[ADDR_SIZE-1:0];
  assign wr_bus.WDATA        = wdata;
  assign wr_bus.WPTR         = wptr_q;
  assign wr_bus.WFULL        = wfull_q;
  assign wr_bus.WALMOST_FULL = wafull_q;
  assign wr_bus.WLEVEL       = wlevel_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fifo_wr_arbiter
//   Directed bench for fifo_wr_arbiter with default parameters
//   (ADDR_SIZE=4, DATA_SIZE=8, NUM_REQ=4, AFULL_TH=2). WQ2_RPTR is driven
//   directly as a Gray value. Inputs change 1ns after the rising edge.
//   Combinational outputs are checked 1ns after that, and registered outputs
//   are checked 1ns after the edge that updates them.
// ---------------------------------------------------------------------------
module tb_fifo_wr_arbiter;

  logic wclk;
  logic wrst;
  int   n_checks;
  int   n_errors;

  fifo_wr_arbiter_if #(.ADDR_SIZE(4), .DATA_SIZE(8), .NUM_REQ(4)) wr_if ();

  fifo_wr_arbiter #(
    .ADDR_SIZE (4),
    .DATA_SIZE (8),
    .NUM_REQ   (4),
    .AFULL_TH  (2)
  ) dut (
    .WCLK   (wclk),
    .WRST   (wrst),
    .wr_bus (wr_if.slave)
  );

  initial begin
    wclk = 1'b0;
    forever #5 wclk = ~wclk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge wclk);
    #1;
  endtask

  logic [3:0] exp_order [8];
  logic [4:0] exp_wrap  [4];
  logic [3:0] exp_waddr [4];

  initial begin
    n_checks = 0;
    n_errors = 0;
    exp_order = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd0, 4'd1, 4'd2, 4'd3};
    exp_wrap  = '{5'b10001, 5'b10000, 5'b00000, 5'b00001};
    exp_waddr = '{4'd14, 4'd15, 4'd0, 4'd1};

    // Requester i presents 0x11*(i+1).
    wrst            = 1'b1;
    wr_if.REQ       = 4'b1111;
    wr_if.REQ_DATA  = {8'h44, 8'h33, 8'h22, 8'h11};
    wr_if.WQ2_RPTR  = 5'b00000;

    // 1. Reset with all requesters active.
    #1;
    check("rst_gnt_comb", 32'(wr_if.GNT), 32'h0);
    check("rst_wclken_comb", 32'(wr_if.WCLKEN), 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_gnt", 32'(wr_if.GNT), 32'h0);
      check("rst_wclken", 32'(wr_if.WCLKEN), 32'h0);
      check("rst_wptr", 32'(wr_if.WPTR), 32'h0);
      check("rst_wfull", 32'(wr_if.WFULL), 32'h0);
      check("rst_wafull", 32'(wr_if.WALMOST_FULL), 32'h0);
      check("rst_wlevel", 32'(wr_if.WLEVEL), 32'h0);
    end

    // 2. Single requester fills the FIFO.
    wrst      = 1'b0;
    wr_if.REQ = 4'b0001;
    for (int i = 0; i < 16; i++) begin
      #1;
      check("fill_gnt", 32'(wr_if.GNT), 32'h1);
      check("fill_waddr", 32'(wr_if.WADDR), 32'(i));
      check("fill_wdata", 32'(wr_if.WDATA), 32'h11);
      tick();
      check("fill_wlevel", 32'(wr_if.WLEVEL), 32'(i + 1));
      check("fill_wafull", 32'(wr_if.WALMOST_FULL), (i + 1 >= 14) ? 32'h1 : 32'h0);
      check("fill_wfull", 32'(wr_if.WFULL), (i == 15) ? 32'h1 : 32'h0);
    end
    check("full_wptr", 32'(wr_if.WPTR), 32'b11000);
    #1;
    check("full_no_gnt", 32'(wr_if.GNT), 32'h0);
    check("full_wdata_zero", 32'(wr_if.WDATA), 32'h0);

    // 4. One read seen: the full flag clears, the pending write goes in, full again.
    wr_if.WQ2_RPTR = 5'b00001;
    #1;
    check("rd_still_full_gnt", 32'(wr_if.GNT), 32'h0);
    tick();
    check("rd_wfull_clr", 32'(wr_if.WFULL), 32'h0);
    check("rd_wlevel", 32'(wr_if.WLEVEL), 32'd15);
    #1;
    check("rd_gnt", 32'(wr_if.GNT), 32'h1);
    check("rd_waddr", 32'(wr_if.WADDR), 32'h0);
    tick();
    check("rd_wfull_set", 32'(wr_if.WFULL), 32'h1);
    check("rd_wlevel_full", 32'(wr_if.WLEVEL), 32'd16);
    check("rd_wptr", 32'(wr_if.WPTR), 32'b11001);
    wr_if.REQ = 4'b0000;

    // 3. Four contending requesters rotate.
    wrst = 1'b1;
    tick();
    wrst           = 1'b0;
    wr_if.WQ2_RPTR = 5'b00000;
    wr_if.REQ      = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      #1;
      check("rr_gnt", 32'(wr_if.GNT), 32'(1) << exp_order[i]);
      check("rr_wdata", 32'(wr_if.WDATA), 32'h11 * (32'(exp_order[i]) + 1));
      check("rr_waddr", 32'(wr_if.WADDR), 32'(i));
      tick();
    end
    check("rr_wlevel", 32'(wr_if.WLEVEL), 32'd8);
    check("rr_wafull", 32'(wr_if.WALMOST_FULL), 32'h0);
    wr_if.REQ = 4'b0000;

    // 5. Pointer wrap: 30 writes with the reader close behind, then 4 more.
    wrst = 1'b1;
    tick();
    wrst      = 1'b0;
    wr_if.REQ = 4'b0001;
    for (int n = 0; n < 30; n++) begin
      wr_if.WQ2_RPTR = 5'(n ^ (n >> 1));
      tick();
    end
    wr_if.WQ2_RPTR = 5'b10001;   // gray(30)
    for (int i = 0; i < 4; i++) begin
      #1;
      check("wrap_wptr", 32'(wr_if.WPTR), 32'(exp_wrap[i]));
      check("wrap_waddr", 32'(wr_if.WADDR), 32'(exp_waddr[i]));
      check("wrap_gnt", 32'(wr_if.GNT), 32'h1);
      tick();
      check("wrap_wfull", 32'(wr_if.WFULL), 32'h0);
      check("wrap_wlevel", 32'(wr_if.WLEVEL), 32'(i + 1));
    end
    check("wrap_wptr_end", 32'(wr_if.WPTR), 32'b00011);
    wr_if.REQ = 4'b0000;

    // 6. Reset mid-burst drops the write, and priority restarts at 0.
    wrst = 1'b1;
    tick();
    wrst           = 1'b0;
    wr_if.WQ2_RPTR = 5'b00000;
    wr_if.REQ      = 4'b1010;
    #1;
    check("mb_gnt0", 32'(wr_if.GNT), 32'b0010);
    check("mb_wdata0", 32'(wr_if.WDATA), 32'h22);
    tick();
    #1;
    check("mb_gnt1", 32'(wr_if.GNT), 32'b1000);
    check("mb_wdata1", 32'(wr_if.WDATA), 32'h44);
    tick();
    check("mb_wlevel_pre", 32'(wr_if.WLEVEL), 32'd2);
    wrst = 1'b1;
    #1;
    check("mb_rst_gnt", 32'(wr_if.GNT), 32'h0);
    check("mb_rst_wclken", 32'(wr_if.WCLKEN), 32'h0);
    tick();
    check("mb_rst_wptr", 32'(wr_if.WPTR), 32'h0);
    check("mb_rst_wlevel", 32'(wr_if.WLEVEL), 32'h0);
    wrst = 1'b0;
    #1;
    check("mb_post_gnt0", 32'(wr_if.GNT), 32'b0010);
    check("mb_post_waddr", 32'(wr_if.WADDR), 32'h0);
    tick();
    #1;
    check("mb_post_gnt1", 32'(wr_if.GNT), 32'b1000);
    tick();
    check("mb_post_wlevel", 32'(wr_if.WLEVEL), 32'd2);
    check("mb_post_wptr", 32'(wr_if.WPTR), 32'b00011);
    wr_if.REQ = 4'b0000;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
